// File: rtl/core_pkg.sv
// core_pkg: shared control-bundle type, opcodes and ALU op classes
package core_pkg;
  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
endpackage

// File: rtl/ctrl_pipe_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones (clk, rst_n async low, inc -> cnt)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through ID/EX, EX/MEM, MEM/WB with load-use stall, branch flush and counters (id_* in, ex_*/mem_*/wb_* stage contents out, stall/flush_ifid comb, *_cnt saturating)
module ctrl_pipe
  import core_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic [1:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  ctrl_t id_w, ex_c;
  logic  mem_memtoreg, take, lu_hz;
  assign id_w = id_valid ? ctrl_t'({id_alusrc, id_memtoreg & id_regwrite, id_regwrite, id_memread,
                                    id_memwrite, id_branch, id_aluop}) : '0;
  assign take = ex_valid & ex_c.branch & ex_branch_taken;
  assign lu_hz = id_valid & ex_valid & ex_c.memread & (ex_rd != '0) & (ex_rd == id_rs1 | ex_rd == id_rs2);
  assign stall = lu_hz & ~take;
  assign flush_ifid = take;
  assign ex_alusrc = ex_c.alusrc;
  assign ex_branch = ex_c.branch;
  assign ex_memread = ex_c.memread;
  assign ex_aluop = ex_c.aluop;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_c <= '0;
      ex_rd <= '0;
    end else if (take || lu_hz) begin
      ex_valid <= 1'b0;
      ex_c <= '0;
      ex_rd <= '0;
    end else begin
      ex_valid <= id_valid;
      ex_c <= id_w;
      ex_rd <= id_valid ? id_rd : '0;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {mem_valid, mem_memtoreg, mem_regwrite, mem_memread, mem_memwrite, mem_rd} <= '0;
      {wb_valid, wb_memtoreg, wb_regwrite, wb_rd} <= '0;
    end else begin
      {mem_valid, mem_memtoreg, mem_regwrite, mem_memread, mem_memwrite, mem_rd} <=
        {ex_valid, ex_c.memtoreg, ex_c.regwrite, ex_c.memread, ex_c.memwrite, ex_rd};
      {wb_valid, wb_memtoreg, wb_regwrite, wb_rd} <= {mem_valid, mem_memtoreg, mem_regwrite, mem_rd};
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst_n(rst_n), .inc(stall), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst_n(rst_n), .inc(take), .cnt(flush_cnt));
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed plus random stimulus against a stage-history model of ctrl_pipe
module tb_ctrl_pipe;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [7:0] C_R = 8'b0010_0010;
  localparam logic [7:0] C_LD = 8'b1111_0000;
  localparam logic [7:0] C_ST = 8'b1000_1000;
  localparam logic [7:0] C_BEQ = 8'b0000_0101;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, id_alusrc = 0, id_memtoreg = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0, id_branch = 0;
  logic [1:0] id_aluop = 0;
  logic [AW-1:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic ex_branch_taken = 0;
  logic stall, flush_ifid, ex_valid, ex_alusrc, ex_branch, ex_memread;
  logic [1:0] ex_aluop;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic mem_valid, mem_memread, mem_memwrite, mem_regwrite, wb_valid, wb_regwrite, wb_memtoreg;
  logic [CW-1:0] stall_cnt, flush_cnt;
  typedef struct packed {
    bit v, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    bit [1:0] aluop;
    bit [AW-1:0] rd;
  } st_t;
  st_t m_ex, m_mem, m_wb;
  int m_sc, m_fc, compared, mismatched;
  bit last_stall, last_take;
  always #5 clk = ~clk;
  ctrl_pipe #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_aluop(id_aluop), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_ifid(flush_ifid), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_memread(ex_memread), .ex_aluop(ex_aluop), .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(bit v, logic [7:0] c, logic [AW-1:0] rd, logic [AW-1:0] rs1, logic [AW-1:0] rs2);
    id_valid = v;
    {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_aluop} = c;
    id_rd = rd;
    id_rs1 = rs1;
    id_rs2 = rs2;
  endtask
  function automatic st_t masked();
    st_t s = '0;
    if (id_valid !== 1'b1) return s;
    s.v = 1;
    s.alusrc = id_alusrc === 1'b1;
    s.regwrite = id_regwrite === 1'b1;
    s.memtoreg = (id_memtoreg === 1'b1) && s.regwrite;
    s.memread = id_memread === 1'b1;
    s.memwrite = id_memwrite === 1'b1;
    s.branch = id_branch === 1'b1;
    s.aluop = id_aluop;
    s.rd = id_rd;
    return s;
  endfunction
  task automatic check_regs();
    chk("ex_valid", ex_valid, m_ex.v);
    chk("ex_alusrc", ex_alusrc, m_ex.alusrc);
    chk("ex_branch", ex_branch, m_ex.branch);
    chk("ex_memread", ex_memread, m_ex.memread);
    chk("ex_aluop", ex_aluop, m_ex.aluop);
    chk("ex_rd", ex_rd, m_ex.rd);
    chk("mem_valid", mem_valid, m_mem.v);
    chk("mem_memread", mem_memread, m_mem.memread);
    chk("mem_memwrite", mem_memwrite, m_mem.memwrite);
    chk("mem_regwrite", mem_regwrite, m_mem.regwrite);
    chk("mem_rd", mem_rd, m_mem.rd);
    chk("wb_valid", wb_valid, m_wb.v);
    chk("wb_regwrite", wb_regwrite, m_wb.regwrite);
    chk("wb_memtoreg", wb_memtoreg, m_wb.memtoreg);
    chk("wb_rd", wb_rd, m_wb.rd);
    chk("stall_cnt", stall_cnt, m_sc);
    chk("flush_cnt", flush_cnt, m_fc);
  endtask
  task automatic tick();
    bit tk, lu;
    #1;
    tk = m_ex.v && m_ex.branch && (ex_branch_taken === 1'b1);
    lu = (id_valid === 1'b1) && m_ex.v && m_ex.memread && m_ex.rd != 0 && (m_ex.rd == id_rs1 || m_ex.rd == id_rs2);
    chk("stall", stall, lu && !tk);
    chk("flush_ifid", flush_ifid, tk);
    m_wb = m_mem;
    m_mem = m_ex;
    m_ex = (tk || lu) ? '0 : masked();
    if (lu && !tk && m_sc < CMAX) m_sc++;
    if (tk && m_fc < CMAX) m_fc++;
    last_stall = lu && !tk;
    last_take = tk;
    @(posedge clk);
    #1;
    check_regs();
  endtask
  task automatic model_reset();
    m_ex = '0;
    m_mem = '0;
    m_wb = '0;
    m_sc = 0;
    m_fc = 0;
    last_stall = 0;
    last_take = 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1;
    drive(1, C_R, 5, 1, 2);
    tick();
    chk("r_ex_valid", ex_valid, 1);
    chk("r_ex_aluop", ex_aluop, 2'b10);
    drive(0, 8'hFF, 7, 7, 7);
    tick();
    chk("r_mem_regwrite", mem_regwrite, 1);
    chk("r_mem_rd", mem_rd, 5);
    tick();
    chk("r_wb_regwrite", wb_regwrite, 1);
    chk("r_wb_memtoreg", wb_memtoreg, 0);
    chk("r_wb_rd", wb_rd, 5);
    drive(1, C_LD, 3, 1, 0);
    tick();
    drive(1, C_R, 4, 3, 2);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick();
    chk("lu_add_in_ex", ex_rd, 4);
    drive(1, C_LD, 0, 1, 0);
    tick();
    drive(1, C_R, 6, 0, 0);
    tick();
    chk("x0_no_stall", ex_rd, 6);
    drive(1, 8'b0001_0101, 3, 1, 2);
    tick();
    drive(1, C_R, 4, 3, 0);
    ex_branch_taken = 1;
    #1;
    chk("br_flush", flush_ifid, 1);
    chk("br_no_stall", stall, 0);
    tick();
    chk("br_bubble", ex_valid, 0);
    chk("br_flush_cnt", flush_cnt, 1);
    ex_branch_taken = 0;
    drive(1, C_ST, 0, 2, 3);
    id_memtoreg = 1'bx;
    tick();
    drive(0, 8'h00, 0, 0, 0);
    tick();
    chk("st_mem_memwrite", mem_memwrite, 1);
    tick();
    chk("st_wb_memtoreg", wb_memtoreg, 0);
    chk("st_no_x", $isunknown({ex_valid, ex_alusrc, ex_branch, ex_memread, ex_aluop, ex_rd, mem_valid, mem_memread,
      mem_memwrite, mem_regwrite, mem_rd, wb_valid, wb_regwrite, wb_memtoreg, wb_rd, stall, flush_ifid}), 0);
    drive(1, C_LD, 1, 1, 0);
    repeat (2 * ((1 << CW) + 3)) tick();
    chk("sat_stall_cnt", stall_cnt, CMAX);
    @(negedge clk);
    rst_n = 0;
    #1;
    model_reset();
    check_regs();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      ex_branch_taken = 1'($urandom);
      if (!last_stall) begin
        if (last_take) drive(0, 8'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        else begin
          int k = $urandom_range(0, 4);
          logic [7:0] c = k == 0 ? C_R : k == 1 ? C_LD : k == 2 ? C_ST : k == 3 ? C_BEQ : 8'($urandom);
          drive($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
      end
      tick();
    end
    ex_branch_taken = 0;
    drive(1, C_R, 5, 9, 9);
    repeat (3) tick();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_regs();
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush_ifid, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Consumer side of the decoded control bundle {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}. It carries the bundle and destination register through the ID/EX, EX/MEM and MEM/WB pipeline registers. It inserts load-use bubbles and branch-flush bubbles, and keeps saturating stall and flush counters. It sits between the decode stage and the EX/MEM/WB datapath of the 5-stage core.

Parameters:
REG_AW, 5, register index width
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded control bits
id_aluop  in  2  decoded ALU op class
id_rs1, id_rs2, id_rd  in  REG_AW each  ID source and destination registers
ex_branch_taken  in  1  EX comparator result for the instruction in EX
stall  out  1  hold PC and the IF/ID register (combinational)
flush_ifid  out  1  invalidate the IF/ID register (combinational)
ex_valid, ex_alusrc, ex_branch, ex_memread  out  1 each  ID/EX register contents
ex_aluop  out  2  ID/EX register contents
ex_rd  out  REG_AW  ID/EX register contents
mem_valid, mem_memread, mem_memwrite, mem_regwrite  out  1 each  EX/MEM register contents
mem_rd  out  REG_AW  EX/MEM register contents
wb_valid, wb_regwrite, wb_memtoreg  out  1 each  MEM/WB register contents
wb_rd  out  REG_AW  MEM/WB register contents
stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all stage registers, including every valid bit, every control bit and every rd, are 0. Both counters are 0.
- Reset mid-operation clears everything immediately. No pending stall or flush survives reset.
- Input masking: the captured word is ANDed with id_valid. memtoreg is also ANDed with id_regwrite. This means X values from decode (store, branch or unknown opcode) never enter the pipe once the bundle is masked.
- take = ex_valid & ex_branch & ex_branch_taken.
- lu_hz = id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
- stall = lu_hz & ~take. flush_ifid = take. Flush has priority over stall.
- Each posedge, ID/EX behaviour:
  - take or lu_hz: load a bubble (all fields 0).
  - otherwise: load the masked ID word.
- Each posedge, EX/MEM and MEM/WB always advance. No back-pressure from downstream.
- EX/MEM takes memtoreg, regwrite, memread, memwrite, rd and valid from ID/EX. memtoreg is held internally for the MEM/WB hop.
- MEM/WB takes memtoreg, regwrite, rd and valid from EX/MEM.
- Latency: an ID word appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later, unless it was bubbled.
- A load-use stall lasts exactly 1 cycle. After it, the load has moved to MEM and lu_hz drops.
- The branch decision is resolved in EX. The wrong-path words in IF/ID and ID are killed in the same edge.
- stall_cnt increments on every cycle where stall=1. flush_cnt increments on every cycle where take=1.
- Both counters saturate at all-ones and never wrap.
- The block does no forwarding. It only exports mem_* and wb_* fields for the forwarding unit.

Decomposition:
- Shared package core_pkg holds:
  - typedef ctrl_t: packed struct {alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]}.
  - Opcode localparams: R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - The ALUOP_* encodings 00, 01, 10.
- One natural sub-module is sat_counter (parameter W, with inc and asynchronous active-low reset). It is instantiated twice.
- Hazard logic and the stage registers stay in ctrl_pipe.

Test Plan:
- Reset: assert rst_n=0 mid-stream with valid words in all stages -> all outputs 0 asynchronously, counters 0.
- R-type: present R-type with rd=5 and no hazard -> ex_valid=1, aluop=10 at +1. mem_regwrite=1, mem_rd=5 at +2. wb_regwrite=1, wb_memtoreg=0, wb_rd=5 at +3.
- Load-use: lw x3 followed by add using rs1=x3 -> stall=1 for exactly 1 cycle, ex_valid=0 bubble, stall_cnt=1. The add reaches EX one cycle later. With rd=x0 instead there is no stall.
- Branch taken: beq in EX with ex_branch_taken=1 and a load-use condition also true -> flush_ifid=1, stall=0, ID/EX bubble, flush_cnt=1.
- Store X-masking: store with id_memtoreg=X -> mem_memwrite=1 and wb_memtoreg=0, with no X on any output.
- Saturation: force 2^CNT_W+3 stall events -> stall_cnt holds 0xFFFF.
